// File: rtl/bp_bedrock_stream_arbiter_pkg.sv
// Shared types for the BedRock stream arbiter: message size encoding, arbiter state
// and a helper that turns a size code into a byte count.
package bp_bedrock_stream_arbiter_pkg;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'b000,
    e_bedrock_msg_size_2   = 3'b001,
    e_bedrock_msg_size_4   = 3'b010,
    e_bedrock_msg_size_8   = 3'b011,
    e_bedrock_msg_size_16  = 3'b100,
    e_bedrock_msg_size_32  = 3'b101,
    e_bedrock_msg_size_64  = 3'b110,
    e_bedrock_msg_size_128 = 3'b111
  } bp_bedrock_msg_size_e;

  typedef enum logic {e_stream_idle, e_stream_busy} bp_bedrock_stream_arb_state_e;

  function automatic int unsigned bp_bedrock_size_to_bytes(input bp_bedrock_msg_size_e size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/bp_bedrock_size_to_len.sv
// Converts a BedRock message size code into a flit count minus one for a given flit width.
// Messages smaller than one flit still take a single flit (len 0).
module bp_bedrock_size_to_len
  import bp_bedrock_stream_arbiter_pkg::*;
  #(parameter int width_p      = 4
  , parameter int flit_width_p = 64
  )
  (input  logic [2:0]         size_i
  , output logic [width_p-1:0] len_o
  );

  int unsigned msg_bits;
  int unsigned flits;

  always_comb begin
    msg_bits = bp_bedrock_size_to_bytes(bp_bedrock_msg_size_e'(size_i)) * 32'd8;
    flits    = msg_bits / 32'(flit_width_p);
    len_o    = (flits <= 32'd1) ? '0 : width_p'(flits - 32'd1);
  end

`ifndef SYNTHESIS
  always_comb begin
    assert (flits <= (32'd1 << width_p));
  end
`endif

endmodule

// File: rtl/bp_bedrock_stream_arbiter.sv
// Round-robin arbiter that shares one outbound BedRock header+data stream among requesters,
// holding the grant for every flit of a message and flagging the last flit.
module bp_bedrock_stream_arbiter
  import bp_bedrock_stream_arbiter_pkg::*;
  #(parameter int num_req_p    = 2
  , parameter int hdr_width_p  = 32
  , parameter int flit_width_p = 64
  , parameter int len_width_p  = 4
  )
  (input  logic                              clk_i
  , input  logic                             reset_n_i
  , input  logic [num_req_p*hdr_width_p-1:0] hdr_i
  , input  logic [num_req_p*3-1:0]           size_i
  , input  logic [num_req_p*flit_width_p-1:0] data_i
  , input  logic [num_req_p-1:0]             v_i
  , output logic [num_req_p-1:0]             ready_and_o
  , output logic [hdr_width_p-1:0]           hdr_o
  , output logic [flit_width_p-1:0]          data_o
  , output logic                             v_o
  , output logic                             last_o
  , input  logic                             ready_and_i
  , output logic [num_req_p-1:0]             grant_o
  );

  localparam int ptr_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  bp_bedrock_stream_arb_state_e state_r;
  logic [len_width_p-1:0]  cnt_r;
  logic [len_width_p-1:0]  len;
  logic [ptr_width_lp-1:0] rr_ptr_r;
  logic [ptr_width_lp-1:0] owner_r;
  logic [ptr_width_lp-1:0] search_idx;
  logic [ptr_width_lp-1:0] grant_idx;
  logic [ptr_width_lp-1:0] next_ptr;
  logic                    search_found;
  logic                    active;
  logic                    handshake;
  logic                    last_flit;
  logic [2:0]              size_sel;
  int                      search_pos;

  logic [hdr_width_p-1:0]  hdr_arr  [num_req_p];
  logic [flit_width_p-1:0] data_arr [num_req_p];
  logic [2:0]              size_arr [num_req_p];

  for (genvar r = 0; r < num_req_p; r++) begin : g_unpack
    assign hdr_arr[r]  = hdr_i[r*hdr_width_p +: hdr_width_p];
    assign data_arr[r] = data_i[r*flit_width_p +: flit_width_p];
    assign size_arr[r] = size_i[r*3 +: 3];
  end

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    search_idx   = rr_ptr_r;
    search_found = 1'b0;
    search_pos   = 0;
    for (int i = 0; i < num_req_p; i++) begin
      search_pos = int'(rr_ptr_r) + i;
      if (search_pos >= num_req_p) search_pos = search_pos - num_req_p;
      if (!search_found && v_i[ptr_width_lp'(search_pos)]) begin
        search_found = 1'b1;
        search_idx   = ptr_width_lp'(search_pos);
      end
    end
  end

  assign grant_idx = (state_r == e_stream_busy) ? owner_r : search_idx;
  assign active    = reset_n_i & ((state_r == e_stream_busy) | search_found);
  assign size_sel  = size_arr[grant_idx];

  bp_bedrock_size_to_len
    #(.width_p(len_width_p), .flit_width_p(flit_width_p))
    size_to_len
    (.size_i(size_sel), .len_o(len));

  assign hdr_o       = hdr_arr[grant_idx];
  assign data_o      = data_arr[grant_idx];
  assign v_o         = active & v_i[grant_idx];
  assign grant_o     = active ? (num_req_p'(1) << grant_idx) : '0;
  assign ready_and_o = grant_o & {num_req_p{ready_and_i}};
  assign last_flit   = (cnt_r == len);
  assign last_o      = v_o & last_flit;
  assign handshake   = v_o & ready_and_i;
  assign next_ptr    = (grant_idx == ptr_width_lp'(num_req_p - 1)) ? '0
                                                                   : grant_idx + ptr_width_lp'(1);

  // cnt is zero while idle, so a single-flit message finishes without ever locking.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= e_stream_idle;
      cnt_r    <= '0;
      rr_ptr_r <= '0;
      owner_r  <= '0;
    end else if (handshake) begin
      if (last_flit) begin
        state_r  <= e_stream_idle;
        cnt_r    <= '0;
        rr_ptr_r <= next_ptr;
      end else begin
        state_r  <= e_stream_busy;
        cnt_r    <= cnt_r + len_width_p'(1);
        owner_r  <= grant_idx;
      end
    end
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) $onehot0(grant_o));
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_r == e_stream_busy) |-> ($stable(size_sel) && $stable(hdr_o)));
`endif

endmodule
